// File: rtl/zigzag_rle.sv
// rtl/zigzag_rle.sv - rounds a quantized 8x8 block, zigzag-scans it and emits JPEG (run, value) tokens
module zigzag_rle #(
    parameter int DATA_WIDTH  = 32,
    parameter int PIXEL_COUNT = 64,
    parameter int FRAC_BITS   = 16,
    parameter int COEF_WIDTH  = 12,
    parameter int RUN_WIDTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] q_block,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [RUN_WIDTH-1:0]              out_run,
    output logic signed [COEF_WIDTH-1:0]      out_value,
    output logic                              out_eob,
    output logic                              out_last
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam int AW = DATA_WIDTH + 1;
    localparam logic [DATA_WIDTH:0] HALF = AW'(1) << (FRAC_BITS - 1);
    localparam logic [DATA_WIDTH:0] MAXV = AW'((1 << (COEF_WIDTH - 1)) - 1);
    localparam logic [RUN_WIDTH-1:0] RUN_MAX = '1;

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [DATA_WIDTH:0] abs_ext(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? ({1'b0, ~x} + 1'b1) : {1'b0, x};
    endfunction

    // Round half away from zero, then clamp symmetrically so -2^(W-1) never appears.
    function automatic logic signed [COEF_WIDTH-1:0] round_coef(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH:0]   mag;
        logic [COEF_WIDTH-1:0] mag_c;
        mag = (abs_ext(x) + HALF) >> FRAC_BITS;
        if (mag > MAXV) mag = MAXV;
        mag_c = mag[COEF_WIDTH-1:0];
        return x[DATA_WIDTH-1] ? -mag_c : mag_c;
    endfunction

    state_t                            state, state_n;
    logic [DATA_WIDTH*PIXEL_COUNT-1:0] blk_q;
    logic [5:0]                        pos, pos_n;
    logic [RUN_WIDTH-1:0]              run, run_n;
    logic                              done, done_n;
    logic                              ov_n, oeob_n, olast_n;
    logic [RUN_WIDTH-1:0]              orun_n;
    logic signed [COEF_WIDTH-1:0]      oval_n;
    logic [PIXEL_COUNT-1:0]            nz;
    logic [5:0]                        last_nz;
    logic [DATA_WIDTH-1:0]             cur_x;
    logic signed [COEF_WIDTH-1:0]      cur_v;
    logic                              cur_nz;
    logic                              accept;

    // A coefficient rounds to nonzero exactly when its magnitude reaches one half.
    always_comb begin
        nz = '0;
        for (int i = 0; i < PIXEL_COUNT; i++)
            nz[i] = abs_ext(blk_q[i*DATA_WIDTH +: DATA_WIDTH]) >= HALF;
    end

    always_comb begin
        last_nz = '0;
        for (int p = 1; p < 64; p++)
            if (nz[ZZ[p]]) last_nz = 6'(p);
    end

    assign cur_x  = blk_q[ZZ[pos]*DATA_WIDTH +: DATA_WIDTH];
    assign cur_v  = round_coef(cur_x);
    assign cur_nz = nz[ZZ[pos]];
    assign accept = out_valid && out_ready;

    always_comb begin
        state_n  = state;
        pos_n    = pos;
        run_n    = run;
        done_n   = done;
        ov_n     = out_valid;
        orun_n   = out_run;
        oval_n   = out_value;
        oeob_n   = out_eob;
        olast_n  = out_last;
        in_ready = (state == IDLE);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_n = SCAN;
                    pos_n   = '0;
                    run_n   = '0;
                    done_n  = 1'b0;
                end
            end
            SCAN: begin
                if (accept) ov_n = 1'b0;
                if (accept && out_last) begin
                    state_n = IDLE;
                    done_n  = 1'b0;
                end else if (!done && (!out_valid || out_ready)) begin
                    if (pos == 6'd0) begin
                        ov_n    = 1'b1;
                        orun_n  = '0;
                        oval_n  = cur_v;
                        oeob_n  = 1'b0;
                        olast_n = 1'b0;
                        pos_n   = pos + 6'd1;
                    end else if (pos > last_nz) begin
                        ov_n    = 1'b1;
                        orun_n  = '0;
                        oval_n  = '0;
                        oeob_n  = 1'b1;
                        olast_n = 1'b1;
                        done_n  = 1'b1;
                    end else if (!cur_nz) begin
                        if (run == RUN_MAX) begin
                            ov_n    = 1'b1;
                            orun_n  = RUN_MAX;
                            oval_n  = '0;
                            oeob_n  = 1'b0;
                            olast_n = 1'b0;
                            run_n   = '0;
                        end else begin
                            run_n = run + 1'b1;
                        end
                        pos_n = pos + 6'd1;
                    end else begin
                        // A nonzero final coefficient closes the block itself; no EOB follows.
                        ov_n    = 1'b1;
                        orun_n  = run;
                        oval_n  = cur_v;
                        oeob_n  = 1'b0;
                        olast_n = (pos == 6'd63);
                        done_n  = (pos == 6'd63);
                        run_n   = '0;
                        pos_n   = pos + 6'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pos       <= '0;
            run       <= '0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_run   <= '0;
            out_value <= '0;
            out_eob   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) blk_q <= q_block;
            state     <= state_n;
            pos       <= pos_n;
            run       <= run_n;
            done      <= done_n;
            out_valid <= ov_n;
            out_run   <= orun_n;
            out_value <= oval_n;
            out_eob   <= oeob_n;
            out_last  <= olast_n;
        end
    end

endmodule

// File: tb/tb_zigzag_rle.sv
// tb/tb_zigzag_rle.sv - scoreboard bench for zigzag_rle against a behavioural token model
module tb_zigzag_rle;

    localparam int DW = 32;
    localparam int PC = 64;
    localparam int CW = 12;
    localparam int RW = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [DW*PC-1:0]   q_block;
    logic               out_valid;
    logic               out_ready;
    logic [RW-1:0]      out_run;
    logic signed [CW-1:0] out_value;
    logic               out_eob;
    logic               out_last;

    zigzag_rle dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .q_block(q_block),
        .out_valid(out_valid), .out_ready(out_ready), .out_run(out_run), .out_value(out_value),
        .out_eob(out_eob), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int run;
        int value;
        bit eob;
        bit last;
    } tok_t;

    tok_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   tok_cnt = 0;
    bit   stall_en = 1'b0;
    bit   in_flight = 1'b0;
    int   zz[64];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Zigzag order generated by walking the anti-diagonals of the 8x8 grid.
    function automatic void build_zz();
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz[n] = r * 8 + (s - r); n++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz[n] = r * 8 + (s - r); n++; end
            end
        end
    endfunction

    function automatic int round_ref(input logic [31:0] x);
        longint s = longint'($signed(x));
        longint a = (s < 0) ? -s : s;
        longint m = (a + 32768) / 65536;
        if (m > 2047) m = 2047;
        return (s < 0) ? -int'(m) : int'(m);
    endfunction

    function automatic tok_t mk(input int r, input int v, input bit e, input bit l);
        tok_t t;
        t.run = r; t.value = v; t.eob = e; t.last = l;
        return t;
    endfunction

    task automatic push_model(input logic [DW*PC-1:0] blk);
        int v[64];
        int last = 0;
        int zeros = 0;
        for (int p = 0; p < 64; p++) begin
            v[p] = round_ref(blk[zz[p]*32 +: 32]);
            if (p > 0 && v[p] != 0) last = p;
        end
        exp_q.push_back(mk(0, v[0], 1'b0, 1'b0));
        for (int p = 1; p <= last; p++) begin
            if (v[p] == 0) begin
                zeros++;
                if (zeros == 16) begin
                    exp_q.push_back(mk(15, 0, 1'b0, 1'b0));
                    zeros = 0;
                end
            end else begin
                exp_q.push_back(mk(zeros, v[p], 1'b0, p == 63));
                zeros = 0;
            end
        end
        if (last < 63) exp_q.push_back(mk(0, 0, 1'b1, 1'b1));
    endtask

    task automatic send_block(input logic [DW*PC-1:0] blk);
        int n = 0;
        while (!in_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", int'(in_ready), 1);
        q_block  = blk;
        in_valid = 1'b1;
        push_model(blk);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_coef(input int dens);
        logic [31:0] x;
        if ($urandom_range(0, 99) < dens) begin
            case ($urandom_range(0, 3))
                0: x = ($urandom_range(1, 40) << 16) | $urandom_range(0, 65535);
                1: x = $urandom;
                2: x = 32'h8000 + $urandom_range(0, 2) - 1;
                default: x = $urandom_range(0, 32767);
            endcase
        end else begin
            x = $urandom_range(0, 32767);
        end
        if ($urandom_range(0, 1) == 1) x = -x;
        return x;
    endfunction

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        tok_t        e;
        bit          held;
        logic [18:0] held_v;
        logic [18:0] cur;
        held = 1'b0;
        held_v = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
                in_flight = 1'b0;
                continue;
            end
            cur = {out_valid, out_run, out_value, out_eob, out_last};
            if (held) check("stall_hold", int'(cur), int'(held_v));
            held = 1'b0;
            if (in_flight) check("in_ready_busy", int'(in_ready), 0);
            if (in_valid && in_ready) in_flight = 1'b1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_token: got run=%0d value=%0d eob=%0d expected none",
                             out_run, out_value, out_eob);
                end else begin
                    e = exp_q.pop_front();
                    check("tok_run", int'(out_run), e.run);
                    check("tok_value", int'(out_value), e.value);
                    check("tok_eob", int'(out_eob), int'(e.eob));
                    check("tok_last", int'(out_last), int'(e.last));
                end
                tok_cnt++;
                if (out_last) in_flight = 1'b0;
            end else if (out_valid) begin
                held = 1'b1;
                held_v = cur;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_run"}, int'(out_run), 0);
        check({tag, "_out_value"}, int'(out_value), 0);
        check({tag, "_out_eob"}, int'(out_eob), 0);
        check({tag, "_out_last"}, int'(out_last), 0);
    endtask

    initial begin
        logic [DW*PC-1:0] blk;
        int base;
        int n;
        build_zz();
        rst = 1'b1;
        in_valid = 1'b0;
        q_block = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        blk = '0;
        send_block(blk);

        blk = '0; blk[0 +: 32] = 32'h000A8000; blk[32 +: 32] = 32'h00030000;
        send_block(blk);
        blk[0 +: 32] = 32'hFFF58000;
        send_block(blk);

        blk = '0; blk[63*32 +: 32] = 32'h00010000;
        send_block(blk);

        blk = '0; blk[0 +: 32] = 32'h7FFF0000;
        send_block(blk);
        blk = '0; blk[0 +: 32] = 32'h80000000; blk[32 +: 32] = 32'h00007FFF;
        blk[2*32 +: 32] = 32'h00008000; blk[8*32 +: 32] = 32'hFFFF8000;
        blk[9*32 +: 32] = 32'hFFFF8001; blk[62*32 +: 32] = 32'h00018000;
        send_block(blk);

        stall_en = 1'b1;
        for (int b = 0; b < 40; b++) begin
            int dens;
            case (b % 4)
                0: dens = 2;
                1: dens = 10;
                2: dens = 40;
                default: dens = 90;
            endcase
            for (int i = 0; i < PC; i++) blk[i*32 +: 32] = rand_coef(dens);
            send_block(blk);
        end

        n = 0;
        while ((exp_q.size() != 0 || in_flight) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_before_reset", exp_q.size(), 0);

        stall_en = 1'b0;
        for (int i = 0; i < PC; i++) blk[i*32 +: 32] = (i + 1) << 16;
        base = tok_cnt;
        send_block(blk);
        n = 0;
        while (tok_cnt < base + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_token3", int'(tok_cnt >= base + 3), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midscan_rst");
        @(posedge clk); #1;
        rst = 1'b0;

        stall_en = 1'b1;
        for (int i = 0; i < PC; i++) blk[i*32 +: 32] = rand_coef(30);
        send_block(blk);

        n = 0;
        while ((exp_q.size() != 0 || in_flight) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("final_drain", exp_q.size(), 0);
        check("final_in_flight", int'(in_flight), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
